serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 144 ++++++++++++++
 tb/tb_serial_addsub.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor.
// One full-add per clock, LSB first. The result, carry, overflow and zero
// outputs are registered and hold until the next operation completes.
// An accepted start spends one IDLE cycle with a pending flag set, then
// WIDTH RUN cycles, then one DONE cycle. This places done exactly
// WIDTH+1 edges after the start edge.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_shift;

    // One-bit full adder on the operand LSBs plus the shifted result word
    always_comb begin
        sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        res_shift = {sum_bit, res_sh_q[WIDTH-1:1]};
    end

    // Next-state logic and datapath updates; everything holds by default
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    // Operands were loaded on the previous edge; begin shifting.
                    pend_d  = 1'b0;
                    state_d = S_RUN;
                end else if (start) begin
                    // Subtract is a + ~b + 1: invert b and seed the carry with op.
                    pend_d  = 1'b1;
                    a_sh_d  = a;
                    b_sh_d  = op ? ~b : b;
                    carry_d = op;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_shift;
                carry_d  = carry_nxt;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB, carry_nxt the carry out.
                    state_d  = S_DONE;
                    result_d = res_shift;
                    cout_d   = carry_nxt;
                    ovf_d    = carry_q ^ carry_nxt;
                    zero_d   = (res_shift == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and visible outputs, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Shift registers, carry and bit counter; always reloaded before use
    always_ff @(posedge clk) begin
        a_sh_q   <= a_sh_d;
        b_sh_q   <= b_sh_d;
        res_sh_q <= res_sh_d;
        carry_q  <= carry_d;
        cnt_q    <= cnt_d;
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH=8): directed corner cases, start
// filtering, reset abort, back-to-back and randomized operations checked
// against an arithmetic reference model.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst, start, op;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf, zero;
    logic [7:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations captured by run_op
    logic [7:0] o_res;
    logic       o_cout, o_ovf, o_zero;
    int         o_lat, o_busy_n, o_extra;
    bit         o_overlap, o_hold_bad;

    serial_addsub #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modulo arithmetic, carry as unsigned range check,
    // overflow as signed range check.
    task automatic model(input logic o, input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] r, output logic c, output logic v, output logic z);
        int ux, uy, sx, sy, ss, us;
        ux = int'(x); uy = int'(y);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        if (o == 1'b0) begin
            us = ux + uy;
            c  = (us > 255);
            ss = sx + sy;
        end else begin
            us = ux - uy + 256;
            c  = (ux >= uy);
            ss = sx - sy;
        end
        r = 8'(us % 256);
        v = (ss > 127) || (ss < -128);
        z = (r == 8'h00);
    endtask

    // Issue one operation and record latency, busy length and outputs.
    // Operand inputs are scrambled every cycle after the start edge.
    // With disturb set, start is pulsed during RUN and in the done cycle.
    task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y, input bit disturb);
        int watch;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        o_lat = 0; o_busy_n = 0; o_overlap = 0; o_extra = 0; o_hold_bad = 0;
        if (busy) o_busy_n++;
        for (int n = 1; n <= 40 && o_lat == 0; n++) begin
            a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
            start = disturb && (n == 4);
            tick();
            start = 1'b0;
            if (busy) o_busy_n++;
            if (busy && done) o_overlap = 1;
            if (done) o_lat = n;
        end
        o_res = result; o_cout = cout; o_ovf = ovf; o_zero = zero;
        if (o_lat != 0) begin
            watch = disturb ? 14 : 1;
            for (int n = 0; n < watch; n++) begin
                if (disturb && n == 0) begin
                    start = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
                end
                tick();
                start = 1'b0;
                if (busy || done) o_extra++;
                if ({result, cout, ovf, zero} !== {o_res, o_cout, o_ovf, o_zero}) o_hold_bad = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        tick(); tick();
        n_cmp++;
        if ({busy, done, result, cout, ovf, zero} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h c=%b v=%b z=%b, want all 0",
                     busy, done, result, cout, ovf, zero);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic       tv_op[7];
        logic [7:0] tv_a[7];
        logic [7:0] tv_b[7];
        logic [7:0] er;
        logic       ec, ev, ez;
        tv_op = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tv_a  = '{8'h0F, 8'h7F, 8'hFF, 8'h05, 8'h00, 8'h80, 8'h80};
        tv_b  = '{8'h01, 8'h01, 8'h01, 8'h05, 8'h01, 8'h01, 8'h80};
        for (int i = 0; i < 7; i++) begin
            model(tv_op[i], tv_a[i], tv_b[i], er, ec, ev, ez);
            run_op(tv_op[i], tv_a[i], tv_b[i], 1'b0);
            n_cmp++;
            if (o_lat !== 9) begin n_bad++; $display("FAIL dir%0d_latency: got %0d, want 9", i, o_lat); end
            n_cmp++;
            if (o_busy_n !== 8) begin n_bad++; $display("FAIL dir%0d_busy_len: got %0d, want 8", i, o_busy_n); end
            n_cmp++;
            if ({o_res, o_cout, o_ovf, o_zero} !== {er, ec, ev, ez}) begin
                n_bad++;
                $display("FAIL dir%0d_result: got %h c=%b v=%b z=%b, want %h c=%b v=%b z=%b",
                         i, o_res, o_cout, o_ovf, o_zero, er, ec, ev, ez);
            end
            n_cmp++;
            if (o_overlap || o_extra != 0 || o_hold_bad) begin
                n_bad++;
                $display("FAIL dir%0d_protocol: got overlap=%b extra=%0d holdbad=%b, want 0/0/0",
                         i, o_overlap, o_extra, o_hold_bad);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] er;
        logic       ec, ev, ez;
        model(1'b0, 8'h3C, 8'h5A, er, ec, ev, ez);
        run_op(1'b0, 8'h3C, 8'h5A, 1'b1);
        n_cmp++;
        if (o_lat !== 9) begin n_bad++; $display("FAIL ign_latency: got %0d, want 9", o_lat); end
        n_cmp++;
        if ({o_res, o_cout, o_ovf, o_zero} !== {er, ec, ev, ez}) begin
            n_bad++;
            $display("FAIL ign_result: got %h c=%b v=%b z=%b, want %h c=%b v=%b z=%b",
                     o_res, o_cout, o_ovf, o_zero, er, ec, ev, ez);
        end
        n_cmp++;
        if (o_extra !== 0 || o_hold_bad) begin
            n_bad++;
            $display("FAIL ign_no_restart: got extra=%0d holdbad=%b, want 0/0", o_extra, o_hold_bad);
        end
    endtask

    task automatic test_abort();
        int seen;
        op = 1'b0; a = 8'h44; b = 8'h21; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, result, cout, ovf, zero} !== 12'h000) begin
            n_bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b res=%h c=%b v=%b z=%b, want all 0",
                     busy, done, result, cout, ovf, zero);
        end
        seen = 0;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (busy || done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles, want 0", seen); end
        // reset and start at the same edge: reset wins
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        tick();
        rst = 1'b0; start = 1'b0;
        seen = 0;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (busy || done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL rst_priority: got %0d active cycles, want 0", seen); end
        run_op(1'b0, 8'h22, 8'h11, 1'b0);
        n_cmp++;
        if (o_lat !== 9 || o_res !== 8'h33) begin
            n_bad++;
            $display("FAIL post_reset_add: got lat=%0d res=%h, want lat=9 res=33", o_lat, o_res);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] er;
        logic       ec, ev, ez;
        logic [7:0] x, y;
        logic       o;
        // run_op leaves the bench in the IDLE cycle right after done,
        // so each following call asserts start at the earliest legal point.
        for (int i = 0; i < 4; i++) begin
            x = 8'($urandom); y = 8'($urandom); o = 1'(i);
            model(o, x, y, er, ec, ev, ez);
            run_op(o, x, y, 1'b0);
            n_cmp++;
            if (o_lat !== 9 || {o_res, o_cout, o_ovf, o_zero} !== {er, ec, ev, ez}) begin
                n_bad++;
                $display("FAIL b2b%0d: got lat=%0d %h c=%b v=%b z=%b, want lat=9 %h c=%b v=%b z=%b",
                         i, o_lat, o_res, o_cout, o_ovf, o_zero, er, ec, ev, ez);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] er;
        logic       ec, ev, ez;
        logic [7:0] x, y;
        logic       o;
        int         bad_here;
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom); y = 8'($urandom); o = 1'($urandom);
            if (i % 50 == 0) y = x;
            model(o, x, y, er, ec, ev, ez);
            run_op(o, x, y, 1'b0);
            bad_here = 0;
            n_cmp++;
            if (o_lat !== 9 || o_busy_n !== 8) begin
                n_bad++; bad_here++;
                $display("FAIL rnd%0d_timing: got lat=%0d busy=%0d, want 9/8", i, o_lat, o_busy_n);
            end
            n_cmp++;
            if ({o_res, o_cout, o_ovf, o_zero} !== {er, ec, ev, ez}) begin
                n_bad++; bad_here++;
                $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %h c=%b v=%b z=%b, want %h c=%b v=%b z=%b",
                         i, o, x, y, o_res, o_cout, o_ovf, o_zero, er, ec, ev, ez);
            end
            n_cmp++;
            if (o_overlap || o_extra != 0 || o_hold_bad) begin
                n_bad++; bad_here++;
                $display("FAIL rnd%0d_protocol: got overlap=%b extra=%0d holdbad=%b, want 0/0/0",
                         i, o_overlap, o_extra, o_hold_bad);
            end
            if (bad_here != 0 && n_bad > 30) break;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
